// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: job sequencer for a weight-stationary ROWS x COLS systolic array
module systolic_array_ctrl #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int OUT_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_vec,
  input  logic                    hold,
  output logic                    busy,
  output logic                    done,
  output logic                    pe_clear_weight,
  output logic                    pe_weight_load,
  output logic                    pe_mac_enable,
  output logic                    wet_rd_en,
  output logic [$clog2(ROWS)-1:0] wet_row_idx,
  output logic                    act_rd_en,
  output logic [COLS-1:0]         out_valid
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = CNT_W + 1;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, STREAM, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, last;
  logic [CNT_W-1:0] nv;
  logic run;
  assign last = {1'b0, nv} + CW'(COLS - 1 + OUT_LAT);
  assign run = !hold || state == IDLE || state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      nv    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && start) nv <= num_vec;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (run) begin
      case (state)
        IDLE:   if (start) begin state_n = CLEAR; cnt_n = '0; end
        CLEAR:  begin state_n = LOAD; cnt_n = '0; end
        LOAD:   if (cnt == CW'(ROWS - 1)) begin
                  state_n = (nv == '0) ? DONE : STREAM;
                  cnt_n   = '0;
                end else cnt_n = cnt + CW'(1);
        STREAM: if (cnt == last - CW'(1)) begin
                  state_n = DONE;
                  cnt_n   = '0;
                end else cnt_n = cnt + CW'(1);
        DONE:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_comb begin
    busy            = state != IDLE;
    done            = state == DONE;
    pe_clear_weight = state == CLEAR && !hold;
    pe_weight_load  = state == LOAD && !hold;
    wet_rd_en       = pe_weight_load;
    wet_row_idx     = (state == LOAD) ? RW'(ROWS - 1) - cnt[RW-1:0] : '0;
    pe_mac_enable   = state == STREAM && !hold;
    act_rd_en       = pe_mac_enable && cnt < {1'b0, nv};
  end
  // window test via wrapped difference avoids constant compares for column 0
  for (genvar c = 0; c < COLS; c++) begin : g_ov
    logic [CW:0] d;
    assign d = {1'b0, cnt} - (CW+1)'(c + OUT_LAT);
    assign out_valid[c] = pe_mac_enable && d < {2'b0, nv};
  end
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb_systolic_array_ctrl: directed table-driven checks of the systolic array sequencer
module tb_systolic_array_ctrl;
  typedef struct packed {
    logic busy, done, clr, wl, mac, wrd;
    logic [1:0] idx;
    logic ard;
    logic [3:0] ov;
  } out_t;
  typedef struct {
    logic start, hold;
    logic [15:0] nv;
    out_t e;
    string nm;
  } vec_t;
  logic clk = 0, reset = 1, start = 0, hold = 0;
  logic [15:0] num_vec = 0;
  logic busy, done, clr, wl, mac, wrd, ard;
  logic [1:0] idx;
  logic [3:0] ov;
  logic [3:0] nv6 = 4'd15;
  logic busy6, done6, clr6, wl6, mac6, wrd6, ard6;
  logic [1:0] idx6;
  logic [3:0] ov6;
  int passed = 0, total = 0, dones = 0;
  int a6 = 0, m6 = 0, v6 = 0, d6 = 0, dc6 = -1, cidx = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  systolic_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .hold(hold),
    .busy(busy), .done(done), .pe_clear_weight(clr), .pe_weight_load(wl),
    .pe_mac_enable(mac), .wet_rd_en(wrd), .wet_row_idx(idx), .act_rd_en(ard),
    .out_valid(ov)
  );
  systolic_array_ctrl #(.CNT_W(4)) u6 (
    .clk(clk), .reset(reset), .start(start), .num_vec(nv6), .hold(hold),
    .busy(busy6), .done(done6), .pe_clear_weight(clr6), .pe_weight_load(wl6),
    .pe_mac_enable(mac6), .wet_rd_en(wrd6), .wet_row_idx(idx6), .act_rd_en(ard6),
    .out_valid(ov6)
  );
  function automatic out_t o_idle();
    return '0;
  endfunction
  function automatic out_t o_clr();
    out_t o = '0; o.busy = 1; o.clr = 1; return o;
  endfunction
  function automatic out_t o_ld(input logic [1:0] i);
    out_t o = '0; o.busy = 1; o.wl = 1; o.wrd = 1; o.idx = i; return o;
  endfunction
  function automatic out_t o_hld(input logic [1:0] i);
    out_t o = '0; o.busy = 1; o.idx = i; return o;
  endfunction
  function automatic out_t o_st(input logic a, input logic [3:0] v);
    out_t o = '0; o.busy = 1; o.mac = 1; o.ard = a; o.ov = v; return o;
  endfunction
  function automatic out_t o_dn();
    out_t o = '0; o.busy = 1; o.done = 1; return o;
  endfunction
  function automatic void add(input logic s, h, input logic [15:0] n, input out_t e, input string nm);
    vec_t v;
    v.start = s; v.hold = h; v.nv = n; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endfunction
  task automatic cyc(input logic r, s, h, input logic [15:0] n, input logic chk, input out_t e, input string nm);
    out_t a;
    reset = r; start = s; hold = h; num_vec = n;
    @(negedge clk);
    a = {busy, done, clr, wl, mac, wrd, idx, ard, ov};
    if (done) dones++;
    if (ard6) a6++;
    if (mac6) m6++;
    if (ov6[3]) v6++;
    if (done6) begin d6++; dc6 = cidx; end
    cidx++;
    if (chk) begin
      total++;
      if (a !== e) $display("FAIL %s: got %h want %h", nm, a, e);
      else passed++;
    end
    @(posedge clk); #1;
  endtask
  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d want %0d", nm, act, exp);
    else passed++;
  endtask
  initial begin
    add(0, 0, 3, o_idle(), "rst_idle");
    add(1, 0, 3, o_idle(), "t1c0");
    add(0, 0, 3, o_clr(), "t1c1");
    add(0, 0, 3, o_ld(3), "t1c2");
    add(0, 0, 3, o_ld(2), "t1c3");
    add(0, 0, 3, o_ld(1), "t1c4");
    add(0, 0, 3, o_ld(0), "t1c5");
    add(0, 0, 3, o_st(1, 4'b0001), "t1c6");
    add(0, 0, 3, o_st(1, 4'b0011), "t1c7");
    add(0, 0, 3, o_st(1, 4'b0111), "t1c8");
    add(0, 0, 3, o_st(0, 4'b1110), "t1c9");
    add(0, 0, 3, o_st(0, 4'b1100), "t1c10");
    add(0, 0, 3, o_st(0, 4'b1000), "t1c11");
    add(0, 0, 3, o_dn(), "t1c12");
    add(0, 0, 3, o_idle(), "t1c13");
    add(1, 0, 0, o_idle(), "t2c0");
    add(0, 0, 0, o_clr(), "t2c1");
    add(0, 0, 0, o_ld(3), "t2c2");
    add(0, 0, 0, o_ld(2), "t2c3");
    add(0, 0, 0, o_ld(1), "t2c4");
    add(0, 0, 0, o_ld(0), "t2c5");
    add(0, 0, 0, o_dn(), "t2c6");
    add(0, 0, 0, o_idle(), "t2c7");
    add(1, 0, 3, o_idle(), "t3c0");
    add(0, 0, 3, o_clr(), "t3c1");
    add(0, 0, 3, o_ld(3), "t3c2");
    add(0, 1, 3, o_hld(2), "t3c3");
    add(0, 1, 3, o_hld(2), "t3c4");
    add(0, 0, 3, o_ld(2), "t3c5");
    add(0, 0, 3, o_ld(1), "t3c6");
    add(0, 0, 3, o_ld(0), "t3c7");
    add(0, 0, 3, o_st(1, 4'b0001), "t3c8");
    add(0, 0, 3, o_st(1, 4'b0011), "t3c9");
    add(0, 0, 3, o_st(1, 4'b0111), "t3c10");
    add(0, 0, 3, o_st(0, 4'b1110), "t3c11");
    add(0, 0, 3, o_st(0, 4'b1100), "t3c12");
    add(0, 0, 3, o_st(0, 4'b1000), "t3c13");
    add(0, 0, 3, o_dn(), "t3c14");
    add(0, 0, 3, o_idle(), "t3c15");
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, o_idle(), "");
    cyc(1, 0, 0, 0, 0, o_idle(), "");
    foreach (tbl[i]) cyc(0, tbl[i].start, tbl[i].hold, tbl[i].nv, 1, tbl[i].e, tbl[i].nm);
    // reset mid-stream aborts, then a fresh start is accepted
    cyc(0, 1, 0, 3, 0, o_idle(), "");
    for (int i = 1; i < 8; i++) cyc(0, 0, 0, 3, 0, o_idle(), "");
    dones = 0;
    cyc(1, 0, 0, 3, 1, o_st(1, 4'b0111), "t4c8");
    cyc(0, 0, 0, 3, 1, o_idle(), "t4c9");
    cyc(0, 1, 0, 3, 1, o_idle(), "t4c10");
    cyc(0, 0, 0, 3, 1, o_clr(), "t4c11");
    chk_int("t4_no_done", dones, 0);
    cyc(1, 0, 0, 3, 0, o_idle(), "");
    cyc(0, 0, 0, 3, 1, o_idle(), "t4_idle");
    dones = 0;
    cyc(0, 1, 0, 3, 1, o_idle(), "t5c0");
    for (int i = 1; i < 4; i++) cyc(0, 0, 0, 3, 0, o_idle(), "");
    cyc(0, 1, 0, 3, 1, o_ld(1), "t5c4");
    for (int i = 5; i < 12; i++) cyc(0, 0, 0, 3, 0, o_idle(), "");
    cyc(0, 1, 0, 3, 1, o_dn(), "t5c12");
    cyc(0, 0, 0, 3, 1, o_idle(), "t5c13");
    cyc(0, 0, 0, 3, 1, o_idle(), "t5c14");
    chk_int("t5_dones", dones, 1);
    cyc(1, 0, 0, 15, 0, o_idle(), "");
    a6 = 0; m6 = 0; v6 = 0; d6 = 0; dc6 = -1; cidx = 0;
    cyc(0, 1, 0, 15, 0, o_idle(), "");
    for (int i = 1; i < 30; i++) cyc(0, 0, 0, 15, 0, o_idle(), "");
    chk_int("t6_act", a6, 15);
    chk_int("t6_mac", m6, 18);
    chk_int("t6_ov3", v6, 15);
    chk_int("t6_dones", d6, 1);
    chk_int("t6_done_cyc", dc6, 24);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
